// File: rtl/wb_prog_loader.sv
// wb_prog_loader: packs a byte stream into words and boots the TMS1x00 core over Wishbone.
// Optional PROG_LOADER_VERIFY_EN adds a readback check after every program word.
module wb_prog_loader (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [9:0]  nwords_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [9:0]  words_o
);
  localparam logic [31:0] PROG_BASE = 32'h3001_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h3080_0000;
  localparam logic [31:0] CTRL_HOLD = 32'h0000_0003;
  localparam logic [31:0] CTRL_RUN = 32'h0000_0000;
  localparam int MAX_WORDS = 512;
  localparam int ACK_TIMEOUT = 255;
  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_GATHER, S_WRITE,
`ifdef PROG_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_GAP, S_RELEASE, S_DONE, S_ERROR
  } state_t;
  state_t state, state_n;
  logic [9:0] nwords_q;
  logic [1:0] bcnt;
  logic [7:0] tmo;
  logic gcnt, idle_like, accept, bad, take, ack, timeout, bus_n;
  assign idle_like = state == S_IDLE || state == S_DONE || state == S_ERROR;
  assign accept = start_i && idle_like;
  assign bad = nwords_i == 10'd0 || nwords_i > 10'(MAX_WORDS);
  assign take = in_valid_i && in_ready_o;
  assign ack = wbm_ack_i && wbm_stb_o;
  assign timeout = wbm_stb_o && !wbm_ack_i && tmo == 8'(ACK_TIMEOUT - 1);
  assign bus_n = state_n == S_HOLD || state_n == S_WRITE || state_n == S_RELEASE
`ifdef PROG_LOADER_VERIFY_EN
    || state_n == S_VERIFY
`endif
    ;
  assign in_ready_o = state == S_GATHER;
  assign busy_o = !idle_like;
  assign done_o = state == S_DONE;
  assign error_o = state == S_ERROR;
  assign wbm_sel_o = 4'hF;
`ifndef PROG_LOADER_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^wbm_dat_i;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_i) state_n = bad ? S_ERROR : S_HOLD;
      S_HOLD: state_n = ack ? S_GATHER : timeout ? S_ERROR : S_HOLD;
      S_GATHER: if (take && bcnt == 2'd3) state_n = S_WRITE;
      S_WRITE: state_n = ack ? S_GAP : timeout ? S_ERROR : S_WRITE;
`ifdef PROG_LOADER_VERIFY_EN
      S_VERIFY: state_n = ack ? (wbm_dat_i != wbm_dat_o ? S_ERROR : S_GAP) : timeout ? S_ERROR : S_VERIFY;
`endif
      S_GAP: begin
        if (gcnt) state_n = words_o == nwords_q ? S_RELEASE : S_GATHER;
`ifdef PROG_LOADER_VERIFY_EN
        if (gcnt && wbm_we_o) state_n = S_VERIFY;
`endif
      end
      S_RELEASE: state_n = ack ? S_DONE : timeout ? S_ERROR : S_RELEASE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      err_code_o <= 2'd0;
      words_o <= '0;
      nwords_q <= '0;
      bcnt <= '0;
      tmo <= '0;
      gcnt <= 1'b0;
    end else begin
      tmo <= wbm_stb_o ? tmo + 8'd1 : 8'd0;
      gcnt <= state == S_GAP && !gcnt;
      wbm_cyc_o <= bus_n;
      wbm_stb_o <= bus_n;
      if (accept) begin
        nwords_q <= nwords_i;
        words_o <= '0;
        err_code_o <= bad ? 2'd1 : 2'd0;
        bcnt <= '0;
      end
      if (accept && !bad) begin
        wbm_adr_o <= CTRL_ADDR;
        wbm_dat_o <= CTRL_HOLD;
        wbm_we_o <= 1'b1;
      end
      if (take) begin
        wbm_dat_o[{bcnt, 3'b000} +: 8] <= in_data_i;
        bcnt <= bcnt + 2'd1;
      end
      if (take && bcnt == 2'd3) begin
        wbm_adr_o <= PROG_BASE + {20'd0, words_o, 2'b00};
        wbm_we_o <= 1'b1;
      end
      if (state == S_WRITE && ack) words_o <= words_o + 10'd1;
      if (timeout) err_code_o <= 2'd2;
      if (state == S_GAP && state_n == S_RELEASE) begin
        wbm_adr_o <= CTRL_ADDR;
        wbm_dat_o <= CTRL_RUN;
        wbm_we_o <= 1'b1;
      end
`ifdef PROG_LOADER_VERIFY_EN
      if (state == S_GAP && state_n == S_VERIFY) wbm_we_o <= 1'b0;
      if (state == S_VERIFY && ack && wbm_dat_i != wbm_dat_o) err_code_o <= 2'd3;
`endif
    end
  end
endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader: vector table of load scenarios against a two-cycle-ack slave model,
// plus sequences for write contents, timeout length, readback and mid-transfer reset.
`timescale 1ns/1ps
module tb_wb_prog_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [9:0] nwords = '0;
  logic [7:0] in_data = '0;
  logic in_ready, we, cyc, stb, busy, done, error;
  logic [31:0] adr, dat;
  logic [3:0] sel;
  logic [1:0] code;
  logic [9:0] words;
  logic [31:0] s_rdata;
  logic s_ack;
  always #5 clk = ~clk;

  wb_prog_loader dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .nwords_i(nwords),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_dat_i(s_rdata), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(s_ack),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(code), .words_o(words)
  );

  // slave: ack two cycles after stb, optional trailing ack pulse, optional hang on 2nd data word
  logic trail_en = 0, hang_en = 0;
  logic [31:0] flip = '0;
  logic [31:0] mem [0:15];
  logic lat, fired, tpend;
  logic [31:0] wlog_adr[$], wlog_dat[$];
  int rd_cnt = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_ack <= 0; lat <= 0; fired <= 0; tpend <= 0; s_rdata <= '0;
    end else begin
      s_ack <= tpend && trail_en;
      tpend <= 0;
      if (!cyc) begin
        fired <= 0; lat <= 0;
      end else if (stb && !fired) begin
        if (!lat) lat <= 1;
        else if (!(hang_en && we && adr == 32'h3001_0004)) begin
          s_ack <= 1; fired <= 1; tpend <= 1;
          if (we) begin
            mem[adr[5:2]] <= dat;
            wlog_adr.push_back(adr);
            wlog_dat.push_back(dat);
          end else begin
            s_rdata <= mem[adr[5:2]] ^ flip;
            rd_cnt <= rd_cnt + 1;
          end
        end
      end
    end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cyc"}, 32'(cyc), 0);
    chk({tag, "_stb"}, 32'(stb), 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_adr"}, adr, 0);
    chk({tag, "_dat"}, dat, 0);
    chk({tag, "_sel"}, 32'(sel), 32'hF);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
    chk({tag, "_code"}, 32'(code), 0);
    chk({tag, "_words"}, 32'(words), 0);
  endtask

  int acc, idle, gap_cfg, stbmax, stbrun, rdybad, nwr, nrd;
  logic busy1;
  task automatic feed_step;
    if (stb) stbrun++; else stbrun = 0;
    if (stbrun > stbmax) stbmax = stbrun;
    if (in_ready && (cyc || !busy)) rdybad++;
    if (idle > 0) begin
      in_valid = 0; idle--;
    end else begin
      in_valid = 1; in_data = 8'(acc + 1);
    end
    if (in_valid && in_ready) begin
      acc++; idle = gap_cfg;
    end
  endtask

  task automatic begin_load(input logic [9:0] nw, input logic tr, input logic hg, input int gp, input logic [31:0] fl);
    trail_en = tr; hang_en = hg; flip = fl; gap_cfg = gp;
    acc = 0; idle = 0; stbmax = 0; stbrun = 0; rdybad = 0;
    @(negedge clk); start = 1; nwords = nw;
    @(negedge clk); start = 0; busy1 = busy;
  endtask

  task automatic run_load(input logic [9:0] nw, input logic tr, input logic hg, input int gp, input logic [31:0] fl);
    int base_w, base_r;
    bit fin;
    fin = 0;
    base_w = wlog_adr.size(); base_r = rd_cnt;
    begin_load(nw, tr, hg, gp, fl);
    for (int c = 0; c < 20000; c++) begin
      if (done || error) begin fin = 1; break; end
      feed_step;
      @(negedge clk);
    end
    in_valid = 0;
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL load_end: got no done/error within 20000 cycles expected done or error");
    end
    repeat (4) @(negedge clk);
    nwr = wlog_adr.size() - base_w;
    nrd = rd_cnt - base_r;
  endtask

  typedef struct {
    logic [9:0] nw; logic trail; logic hang; int gap;
    logic e_done; logic e_err; logic e_busy; logic [1:0] e_code; logic [9:0] e_words;
    int e_writes; int e_bytes;
  } vec_t;
  vec_t tbl [7];
  logic [31:0] exp_adr [5];
  logic [31:0] exp_dat [5];

  initial begin
    tbl[0] = '{10'd3,   1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1, 2'd0, 10'd3,   5,   12};
    tbl[1] = '{10'd3,   1'b0, 1'b0, 50, 1'b1, 1'b0, 1'b1, 2'd0, 10'd3,   5,   12};
    tbl[2] = '{10'd3,   1'b1, 1'b1, 0,  1'b0, 1'b1, 1'b1, 2'd2, 10'd1,   2,   8};
    tbl[3] = '{10'd0,   1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0, 2'd1, 10'd0,   0,   0};
    tbl[4] = '{10'd513, 1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0, 2'd1, 10'd0,   0,   0};
    tbl[5] = '{10'd1,   1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, 2'd0, 10'd1,   3,   4};
    tbl[6] = '{10'd512, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1, 2'd0, 10'd512, 514, 2048};
    exp_adr = '{32'h3080_0000, 32'h3001_0000, 32'h3001_0004, 32'h3001_0008, 32'h3080_0000};
    exp_dat = '{32'h3, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h0};
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      int e_rd;
`ifdef PROG_LOADER_VERIFY_EN
      e_rd = int'(tbl[i].e_words);
`else
      e_rd = 0;
`endif
      run_load(tbl[i].nw, tbl[i].trail, tbl[i].hang, tbl[i].gap, 32'h0);
      chk($sformatf("v%0d_busy_start", i), 32'(busy1), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_code", i), 32'(code), 32'(tbl[i].e_code));
      chk($sformatf("v%0d_words", i), 32'(words), 32'(tbl[i].e_words));
      chk($sformatf("v%0d_writes", i), 32'(nwr), 32'(tbl[i].e_writes));
      chk($sformatf("v%0d_reads", i), 32'(nrd), 32'(e_rd));
      chk($sformatf("v%0d_bytes", i), 32'(acc), 32'(tbl[i].e_bytes));
      chk($sformatf("v%0d_rdy_outside", i), 32'(rdybad), 0);
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
      chk($sformatf("v%0d_cyc_end", i), 32'(cyc), 0);
    end

    // exact write sequence for a three-word load
    begin
      int base;
      base = wlog_adr.size();
      run_load(10'd3, 1'b1, 1'b0, 0, 32'h0);
      if (wlog_adr.size() < base + 5) begin
        n_cmp++; n_bad++;
        $display("FAIL seq_count: got %0d expected 5", wlog_adr.size() - base);
      end else
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("seq%0d_adr", k), wlog_adr[base + k], exp_adr[k]);
          chk($sformatf("seq%0d_dat", k), wlog_dat[base + k], exp_dat[k]);
        end
    end

    // strobe held for the full timeout window, then dropped
    run_load(10'd3, 1'b0, 1'b1, 0, 32'h0);
    chk("tmo_len_in_range", 32'(stbmax >= 254 && stbmax <= 256), 1);
    chk("tmo_code", 32'(code), 2);

`ifdef PROG_LOADER_VERIFY_EN
    run_load(10'd3, 1'b1, 1'b0, 0, 32'h1);
    chk("vfy_error", 32'(error), 1);
    chk("vfy_code", 32'(code), 3);
    chk("vfy_words", 32'(words), 1);
`endif

    // ignored start while busy, then reset while the second data write is pending
    begin
      bit hit;
      hit = 0;
      begin_load(10'd3, 1'b1, 1'b1, 0, 32'h0);
      for (int c = 0; c < 3000; c++) begin
        if (cyc && adr == 32'h3001_0004) begin hit = 1; break; end
        feed_step;
        @(negedge clk);
      end
      in_valid = 0;
      chk("mid_reached", 32'(hit), 1);
      start = 1; nwords = 10'd0;
      @(negedge clk); start = 0;
      @(negedge clk);
      chk("busy_start_ignored_err", 32'(error), 0);
      chk("busy_start_ignored_busy", 32'(busy), 1);
      chk("busy_start_ignored_cyc", 32'(cyc), 1);
      rst_n = 0;
      #1;
      chk_reset("midrst");
      @(negedge clk); rst_n = 1; hang_en = 0;
      @(negedge clk);
      run_load(10'd2, 1'b1, 1'b0, 0, 32'h0);
      chk("recover_done", 32'(done), 1);
      chk("recover_words", 32'(words), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
